// File: rtl/vid_bt656_line_capture_if.sv
// Video byte stream in, line-memory write port and line-ready record out.
// master = capture block, slave = pad logic / line memory / read side.
interface vid_bt656_line_capture_if #(
  parameter int LINE_W = 10
);
  logic [7:0]        vid_data;
  logic              vid_valid;
  logic              w_buf;
  logic [8:0]        w_pix;
  logic              w_ena;
  logic [31:0]       w_data;
  logic              lr_valid;
  logic              lr_buf;
  logic [8:0]        lr_len;
  logic              lr_field;
  logic              lr_ovf;
  logic [LINE_W-1:0] lr_line;

  modport master (
    input  vid_data, vid_valid,
    output w_buf, w_pix, w_ena, w_data,
    output lr_valid, lr_buf, lr_len, lr_field, lr_ovf, lr_line
  );

  modport slave (
    output vid_data, vid_valid,
    input  w_buf, w_pix, w_ena, w_data,
    input  lr_valid, lr_buf, lr_len, lr_field, lr_ovf, lr_line
  );
endinterface

// File: rtl/vid_bt656_line_capture.sv
// BT.656 line capture: TRS decode, Cb/Y/Cr/Y word packing, dual-buffer line
// memory write port and per-line completion record.
module vid_bt656_line_capture #(
  parameter int MAX_PIX = 360,
  parameter int LINE_W  = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cfg_ena,
  output logic stat_trs_err,
  vid_bt656_line_capture_if.master bus
);
  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACTIVE = 1'b1;
  localparam logic [8:0] MAX_W    = 9'(MAX_PIX);

  logic [0:0]        st_q, st_d;
  logic [7:0]        h2_q, h1_q, h0_q, h2_d, h1_d, h0_d;
  logic [1:0]        ph_q, ph_d;
  logic [8:0]        cnt_q, cnt_d;
  logic              ovf_q, ovf_d, field_q, field_d, wbuf_q, wbuf_d;
  logic [LINE_W-1:0] line_q, line_d;
  logic              w_ena_q, w_ena_d;
  logic [8:0]        w_pix_q, w_pix_d;
  logic [31:0]       w_data_q, w_data_d;
  logic              lr_valid_q, lr_valid_d, lr_buf_q, lr_buf_d;
  logic [8:0]        lr_len_q, lr_len_d;
  logic              lr_field_q, lr_field_d, lr_ovf_q, lr_ovf_d;
  logic [LINE_W-1:0] lr_line_q, lr_line_d;
  logic              trs_err_q;

  logic [7:0] xy;
  logic       acc, f, v, h, trs_hit, prot_ok, trs_ok, trs_bad;

  assign acc     = bus.vid_valid;
  assign xy      = bus.vid_data;
  assign f       = xy[6];
  assign v       = xy[5];
  assign h       = xy[4];
  // Preamble match on raw byte history, so codes are found at any alignment.
  assign trs_hit = acc && (h2_q == 8'hFF) && (h1_q == 8'h00) && (h0_q == 8'h00);
  assign prot_ok = (xy[3:0] == {v ^ h, f ^ h, f ^ v, f ^ v ^ h});
  assign trs_ok  = trs_hit && prot_ok;
  assign trs_bad = trs_hit && !prot_ok;

  always_comb begin
    st_d       = st_q;
    h2_d       = h2_q;
    h1_d       = h1_q;
    h0_d       = h0_q;
    ph_d       = ph_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    field_d    = field_q;
    wbuf_d     = wbuf_q;
    line_d     = line_q;
    w_ena_d    = 1'b0;
    w_pix_d    = w_pix_q;
    w_data_d   = w_data_q;
    lr_valid_d = 1'b0;
    lr_buf_d   = lr_buf_q;
    lr_len_d   = lr_len_q;
    lr_field_d = lr_field_q;
    lr_ovf_d   = lr_ovf_q;
    lr_line_d  = lr_line_q;
    if (acc) begin
      h2_d = h1_q;
      h1_d = h0_q;
      h0_d = xy;
      ph_d = trs_ok ? 2'd0 : ph_q + 2'd1;
      if (st_q == S_ACTIVE && !cfg_ena) begin
        st_d = S_IDLE;
      end else if (trs_ok) begin
        if (!h) begin
          if (v || !cfg_ena) begin
            st_d = S_IDLE;
          end else begin
            st_d    = S_ACTIVE;
            field_d = f;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end else if (st_q == S_ACTIVE) begin
          st_d       = S_IDLE;
          lr_valid_d = 1'b1;
          lr_buf_d   = wbuf_q;
          lr_len_d   = cnt_q;
          lr_field_d = field_q;
          lr_ovf_d   = ovf_q;
          lr_line_d  = line_q;
          wbuf_d     = ~wbuf_q;
          line_d     = line_q + 1'b1;
        end
      end else if (st_q == S_ACTIVE && ph_q == 2'd3 && !trs_hit) begin
        if (cnt_q < MAX_W) begin
          w_ena_d  = 1'b1;
          w_pix_d  = cnt_q;
          w_data_d = {h2_q, h1_q, h0_q, xy};
          cnt_d    = cnt_q + 9'd1;
        end else begin
          ovf_d = 1'b1;
        end
      end
      if (trs_ok && v) line_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q       <= S_IDLE;
      h2_q       <= '0;
      h1_q       <= '0;
      h0_q       <= '0;
      ph_q       <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      field_q    <= 1'b0;
      wbuf_q     <= 1'b0;
      line_q     <= '0;
      w_ena_q    <= 1'b0;
      w_pix_q    <= '0;
      w_data_q   <= '0;
      lr_valid_q <= 1'b0;
      lr_buf_q   <= 1'b0;
      lr_len_q   <= '0;
      lr_field_q <= 1'b0;
      lr_ovf_q   <= 1'b0;
      lr_line_q  <= '0;
      trs_err_q  <= 1'b0;
    end else begin
      st_q       <= st_d;
      h2_q       <= h2_d;
      h1_q       <= h1_d;
      h0_q       <= h0_d;
      ph_q       <= ph_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      field_q    <= field_d;
      wbuf_q     <= wbuf_d;
      line_q     <= line_d;
      w_ena_q    <= w_ena_d;
      w_pix_q    <= w_pix_d;
      w_data_q   <= w_data_d;
      lr_valid_q <= lr_valid_d;
      lr_buf_q   <= lr_buf_d;
      lr_len_q   <= lr_len_d;
      lr_field_q <= lr_field_d;
      lr_ovf_q   <= lr_ovf_d;
      lr_line_q  <= lr_line_d;
      trs_err_q  <= trs_bad;
    end
  end

  assign bus.w_buf    = wbuf_q;
  assign bus.w_pix    = w_pix_q;
  assign bus.w_ena    = w_ena_q;
  assign bus.w_data   = w_data_q;
  assign bus.lr_valid = lr_valid_q;
  assign bus.lr_buf   = lr_buf_q;
  assign bus.lr_len   = lr_len_q;
  assign bus.lr_field = lr_field_q;
  assign bus.lr_ovf   = lr_ovf_q;
  assign bus.lr_line  = lr_line_q;
  assign stat_trs_err = trs_err_q;
endmodule

// File: tb/tb_vid_bt656_line_capture.sv
// Bench for vid_bt656_line_capture: table of line scenarios plus hand-written
// restart and reset sequences, with write/line-ready scoreboards.
module tb_vid_bt656_line_capture;
  localparam int LINE_W = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_ena = 1'b0;
  logic stat_trs_err;

  vid_bt656_line_capture_if #(.LINE_W(LINE_W)) bus ();

  vid_bt656_line_capture #(.MAX_PIX(360), .LINE_W(LINE_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_ena      (cfg_ena),
    .stat_trs_err (stat_trs_err),
    .bus          (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sav;
    logic [7:0] eav;
    logic       eav_en;
    logic       cfg;
    logic       gap;
    int         n;
    int         nwr;
    logic       lr;
    int         len;
    logic       ovf;
    logic       fld;
    logic       lbuf;
    int         line;
    int         err;
    logic       wbuf;
  } vec_t;

  typedef struct {
    logic [8:0]  pix;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    logic [8:0]        len;
    logic              lbuf;
    logic              ovf;
    logic              fld;
    logic [LINE_W-1:0] line;
  } lr_t;

  int   checks = 0;
  int   failures = 0;
  int   err_seen = 0;
  logic gap = 1'b0;
  wr_t  wr_q[$];
  lr_t  lr_q[$];
  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t w;
    lr_t l;
    if (bus.w_ena === 1'b1) begin
      chk("write_expected", 32'(wr_q.size() > 0), 32'd1);
      if (wr_q.size() > 0) begin
        w = wr_q.pop_front();
        chk("w_pix", 32'(bus.w_pix), 32'(w.pix));
        chk("w_data", bus.w_data, w.data);
      end
    end
    if (bus.lr_valid === 1'b1) begin
      chk("lr_expected", 32'(lr_q.size() > 0), 32'd1);
      if (lr_q.size() > 0) begin
        l = lr_q.pop_front();
        chk("lr_len", 32'(bus.lr_len), 32'(l.len));
        chk("lr_buf", 32'(bus.lr_buf), 32'(l.lbuf));
        chk("lr_ovf", 32'(bus.lr_ovf), 32'(l.ovf));
        chk("lr_field", 32'(bus.lr_field), 32'(l.fld));
        chk("lr_line", 32'(bus.lr_line), 32'(l.line));
      end
    end
    if (stat_trs_err === 1'b1) err_seen++;
  endtask

  task automatic cycle(input logic [7:0] d, input logic v);
    @(negedge clk);
    monitor();
    bus.vid_data  = d;
    bus.vid_valid = v;
  endtask

  task automatic put(input logic [7:0] d);
    cycle(d, 1'b1);
    if (gap) cycle(8'hFF, 1'b0);
  endtask

  task automatic trs(input logic [7:0] xy);
    put(8'hFF); put(8'h00); put(8'h00); put(xy);
  endtask

  task automatic ramp(input int n);
    for (int k = 0; k < n; k++) put(8'(k));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cycle(8'h00, 1'b0);
  endtask

  task automatic push_words(input int n);
    wr_t w;
    for (int i = 0; i < n; i++) begin
      w.pix  = 9'(i);
      w.data = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
      wr_q.push_back(w);
    end
  endtask

  task automatic push_lr(input int len, input logic lbuf, input logic ovf,
                         input logic fld, input int line);
    lr_t l;
    l.len = 9'(len); l.lbuf = lbuf; l.ovf = ovf; l.fld = fld; l.line = LINE_W'(line);
    lr_q.push_back(l);
  endtask

  initial begin
    //           sav    eav    een  cfg  gap  n     nwr  lr   len  ovf  fld  lbuf line err wbuf
    vecs[0] = '{8'h80, 8'h9D, 1'b1, 1'b1, 1'b0, 1440, 360, 1'b1, 360, 1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    vecs[1] = '{8'h80, 8'h9D, 1'b1, 1'b1, 1'b0, 1600, 360, 1'b1, 360, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0};
    vecs[2] = '{8'h80, 8'h9D, 1'b1, 1'b1, 1'b1, 1440, 360, 1'b1, 360, 1'b0, 1'b0, 1'b0, 2, 0, 1'b1};
    vecs[3] = '{8'h80, 8'h9D, 1'b1, 1'b0, 1'b0, 40,   0,   1'b0, 0,   1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    vecs[4] = '{8'hAB, 8'h00, 1'b0, 1'b1, 1'b0, 0,    0,   1'b0, 0,   1'b0, 1'b0, 1'b0, 0, 0, 1'b1};
    vecs[5] = '{8'h80, 8'h9D, 1'b1, 1'b1, 1'b0, 40,   10,  1'b1, 10,  1'b0, 1'b0, 1'b1, 0, 0, 1'b0};
    vecs[6] = '{8'h80, 8'h9D, 1'b1, 1'b1, 1'b0, 0,    0,   1'b1, 0,   1'b0, 1'b0, 1'b0, 1, 0, 1'b1};
    vecs[7] = '{8'h81, 8'h00, 1'b0, 1'b1, 1'b0, 8,    0,   1'b0, 0,   1'b0, 1'b0, 1'b0, 0, 1, 1'b1};
    vecs[8] = '{8'h80, 8'h9D, 1'b1, 1'b1, 1'b1, 12,   3,   1'b1, 3,   1'b0, 1'b0, 1'b1, 2, 0, 1'b0};
    vecs[9] = '{8'hC7, 8'hDA, 1'b1, 1'b1, 1'b0, 8,    2,   1'b1, 2,   1'b0, 1'b1, 1'b0, 3, 0, 1'b1};

    bus.vid_data  = 8'h00;
    bus.vid_valid = 1'b0;
    idle(3);
    chk("rst_w_ena", 32'(bus.w_ena), 32'd0);
    chk("rst_w_buf", 32'(bus.w_buf), 32'd0);
    chk("rst_lr_valid", 32'(bus.lr_valid), 32'd0);
    chk("rst_lr_line", 32'(bus.lr_line), 32'd0);
    chk("rst_trs_err", 32'(stat_trs_err), 32'd0);
    rst_n = 1'b1;
    idle(2);

    for (int i = 0; i < 10; i++) begin
      int e0;
      e0 = err_seen;
      cfg_ena = vecs[i].cfg;
      gap     = vecs[i].gap;
      push_words(vecs[i].nwr);
      if (vecs[i].lr)
        push_lr(vecs[i].len, vecs[i].lbuf, vecs[i].ovf, vecs[i].fld, vecs[i].line);
      trs(vecs[i].sav);
      ramp(vecs[i].n);
      if (vecs[i].eav_en) trs(vecs[i].eav);
      idle(3);
      chk($sformatf("v%0d_writes_left", i), 32'(wr_q.size()), 32'd0);
      chk($sformatf("v%0d_lr_left", i), 32'(lr_q.size()), 32'd0);
      chk($sformatf("v%0d_trs_err", i), 32'(err_seen - e0), 32'(vecs[i].err));
      chk($sformatf("v%0d_w_buf", i), 32'(bus.w_buf), 32'(vecs[i].wbuf));
      wr_q.delete();
      lr_q.delete();
      gap = 1'b0;
    end

    // SAV restart mid-line: partial line discarded, same buffer, count restarts
    cfg_ena = 1'b1;
    push_words(25);
    trs(8'h80);
    ramp(100);
    push_words(2);
    trs(8'h80);
    ramp(8);
    push_lr(2, 1'b1, 1'b0, 1'b0, 4);
    trs(8'h9D);
    idle(3);
    chk("restart_writes_left", 32'(wr_q.size()), 32'd0);
    chk("restart_lr_left", 32'(lr_q.size()), 32'd0);
    chk("restart_w_buf", 32'(bus.w_buf), 32'd0);
    chk("lr_len_hold", 32'(bus.lr_len), 32'd2);
    chk("lr_line_hold", 32'(bus.lr_line), 32'd4);
    wr_q.delete();
    lr_q.delete();

    // Reset mid-line: everything back to zero, no completion afterwards
    push_words(10);
    trs(8'h80);
    ramp(42);
    idle(1);
    chk("prerst_writes_left", 32'(wr_q.size()), 32'd0);
    rst_n = 1'b0;
    idle(2);
    chk("midrst_w_buf", 32'(bus.w_buf), 32'd0);
    chk("midrst_w_pix", 32'(bus.w_pix), 32'd0);
    chk("midrst_w_data", bus.w_data, 32'd0);
    chk("midrst_lr_len", 32'(bus.lr_len), 32'd0);
    chk("midrst_lr_line", 32'(bus.lr_line), 32'd0);
    chk("midrst_lr_buf", 32'(bus.lr_buf), 32'd0);
    rst_n = 1'b1;
    trs(8'h9D);
    idle(3);
    push_words(2);
    push_lr(2, 1'b0, 1'b0, 1'b0, 0);
    trs(8'h80);
    ramp(8);
    trs(8'h9D);
    idle(3);
    chk("postrst_writes_left", 32'(wr_q.size()), 32'd0);
    chk("postrst_lr_left", 32'(lr_q.size()), 32'd0);
    chk("postrst_w_buf", 32'(bus.w_buf), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
